// File: rtl/bits_needed_tracker_if.sv
// ============================================================================
// Module  : bits_needed_tracker_if
// Purpose : Consume / byte-fetch handshake bundle for bits_needed_tracker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bits_needed_tracker_if #(
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 5,
    parameter int BCNT_W  = 16
) ();
    logic               init;
    logic               consume_valid;
    logic [SHIFT_W-1:0] consume_bits;
    logic               consume_ready;
    logic               byte_req;
    logic               byte_valid;
    logic [7:0]         byte_in;
    logic               byte_load;
    logic [7:0]         byte_out;
    logic [CNT_W-1:0]   insert_pos;
    logic [CNT_W-1:0]   bits_needed;
    logic [BCNT_W-1:0]  bytes_fetched;
    logic               shift_err;

    modport master (
        output init, consume_valid, consume_bits, byte_valid, byte_in,
        input  consume_ready, byte_req, byte_load, byte_out, insert_pos,
               bits_needed, bytes_fetched, shift_err
    );

    modport slave (
        input  init, consume_valid, consume_bits, byte_valid, byte_in,
        output consume_ready, byte_req, byte_load, byte_out, insert_pos,
               bits_needed, bytes_fetched, shift_err
    );
endinterface

`default_nettype wire

// File: rtl/bits_needed_tracker.sv
// ============================================================================
// Module  : bits_needed_tracker
// Purpose : Tracks signed bits-needed count of an arithmetic decoder and
//           requests bitstream bytes whenever the count becomes non-negative.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bits_needed_tracker #(
    parameter int MAX_SHIFT = 8,
    parameter int CNT_W     = 5,
    parameter int SHIFT_W   = 5,
    parameter int BCNT_W    = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    bits_needed_tracker_if.slave trk_if
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    localparam logic [SHIFT_W-1:0] MAX_SHIFT_V = SHIFT_W'(MAX_SHIFT);
    localparam logic [CNT_W-1:0]   BITS_INIT   = CNT_W'(-8);
    localparam logic [CNT_W-1:0]   BYTE_BITS   = CNT_W'(8);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bits_q, bits_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [7:0]          byte_q, byte_d;
    logic [CNT_W-1:0]    pos_q, pos_d;
    logic                load_q, load_d;
    logic                err_q, err_d;

    logic                shift_over;
    logic [SHIFT_W-1:0]  shift_clamped;
    logic [CNT_W-1:0]    bits_sum;
    logic [CNT_W-1:0]    bits_dec;

    // Counter is two's complement; modular add is exact because the result
    // always fits in CNT_W bits, so only the MSB is needed as the sign.
    assign shift_over    = (trk_if.consume_bits > MAX_SHIFT_V);
    assign shift_clamped = shift_over ? MAX_SHIFT_V : trk_if.consume_bits;
    assign bits_sum      = bits_q + CNT_W'(shift_clamped);
    assign bits_dec      = bits_q - BYTE_BITS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bits_q  <= BITS_INIT;
            bcnt_q  <= '0;
            byte_q  <= '0;
            pos_q   <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            bcnt_q  <= bcnt_d;
            byte_q  <= byte_d;
            pos_q   <= pos_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        bcnt_d  = bcnt_q;
        byte_d  = byte_q;
        pos_d   = pos_q;
        load_d  = 1'b0;
        err_d   = err_q;
        if (trk_if.init) begin
            state_d = ST_RUN;
            bits_d  = BITS_INIT;
            bcnt_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (trk_if.consume_valid) begin
                        bits_d  = bits_sum;
                        err_d   = err_q | shift_over;
                        state_d = bits_sum[CNT_W-1] ? ST_RUN : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (trk_if.byte_valid) begin
                        load_d  = 1'b1;
                        byte_d  = trk_if.byte_in;
                        pos_d   = bits_q;
                        bits_d  = bits_dec;
                        bcnt_d  = bcnt_q + 1'b1;
                        state_d = bits_dec[CNT_W-1] ? ST_RUN : ST_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode the state register directly so that an
    // asynchronous reset drops them without waiting for a clock.
    assign trk_if.consume_ready = (state_q == ST_RUN);
    assign trk_if.byte_req      = (state_q == ST_FETCH);
    assign trk_if.byte_load     = load_q;
    assign trk_if.byte_out      = byte_q;
    assign trk_if.insert_pos    = pos_q;
    assign trk_if.bits_needed   = bits_q;
    assign trk_if.bytes_fetched = bcnt_q;
    assign trk_if.shift_err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bits_needed_tracker.sv
// ============================================================================
// Module  : tb_bits_needed_tracker
// Purpose : Self-checking bench; two tracker instances (MAX_SHIFT 8 and 16)
//           driven in lockstep and compared against an integer model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bits_needed_tracker;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_FETCH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       d_init, d_cv, d_bv;
    logic [4:0] d_cb;
    logic [7:0] d_bi;

    int n_pass  = 0;
    int n_total = 0;

    int         m_st [2];
    int         m_bn [2];
    int         m_bc [2];
    int         m_ip [2];
    logic       m_err[2];
    logic       m_bl [2];
    logic [7:0] m_bo [2];

    bits_needed_tracker_if #(.SHIFT_W(5), .CNT_W(5), .BCNT_W(16)) b8  ();
    bits_needed_tracker_if #(.SHIFT_W(5), .CNT_W(6), .BCNT_W(16)) b16 ();

    assign b8.init          = d_init;
    assign b8.consume_valid = d_cv;
    assign b8.consume_bits  = d_cb;
    assign b8.byte_valid    = d_bv;
    assign b8.byte_in       = d_bi;
    assign b16.init          = d_init;
    assign b16.consume_valid = d_cv;
    assign b16.consume_bits  = d_cb;
    assign b16.byte_valid    = d_bv;
    assign b16.byte_in       = d_bi;

    bits_needed_tracker #(.MAX_SHIFT(8), .CNT_W(5), .SHIFT_W(5), .BCNT_W(16))
        u_dut8  (.clk(clk), .rst(rst), .trk_if(b8));
    bits_needed_tracker #(.MAX_SHIFT(16), .CNT_W(6), .SHIFT_W(5), .BCNT_W(16))
        u_dut16 (.clk(clk), .rst(rst), .trk_if(b16));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = S_IDLE; m_bn[k] = -8; m_bc[k] = 0; m_ip[k] = 0;
            m_err[k] = 1'b0;  m_bl[k] = 1'b0; m_bo[k] = 8'h00;
        end
    endtask

    task automatic model_step(input int k, input int maxs);
        int c;
        if (d_init) begin
            m_st[k] = S_RUN; m_bn[k] = -8; m_bc[k] = 0; m_err[k] = 1'b0; m_bl[k] = 1'b0;
        end else begin
            m_bl[k] = 1'b0;
            if (m_st[k] == S_RUN && d_cv) begin
                c = (int'(d_cb) > maxs) ? maxs : int'(d_cb);
                if (int'(d_cb) > maxs) m_err[k] = 1'b1;
                m_bn[k] = m_bn[k] + c;
                m_st[k] = (m_bn[k] >= 0) ? S_FETCH : S_RUN;
            end else if (m_st[k] == S_FETCH && d_bv) begin
                m_bl[k] = 1'b1;
                m_bo[k] = d_bi;
                m_ip[k] = m_bn[k];
                m_bn[k] = m_bn[k] - 8;
                m_bc[k] = (m_bc[k] + 1) % 65536;
                m_st[k] = (m_bn[k] >= 0) ? S_FETCH : S_RUN;
            end
        end
    endtask

    task automatic check_inst(input string tag, input int k, input int cw,
                              input logic cr, input logic br, input logic bl,
                              input logic [7:0] bo, input logic [31:0] ip,
                              input logic [31:0] bn, input logic [31:0] bc,
                              input logic err);
        logic [31:0] mask;
        mask = (32'd1 << cw) - 32'd1;
        chk({tag, ".ready"}, 32'(cr),  32'(m_st[k] == S_RUN));
        chk({tag, ".req"},   32'(br),  32'(m_st[k] == S_FETCH));
        chk({tag, ".load"},  32'(bl),  32'(m_bl[k]));
        chk({tag, ".bout"},  32'(bo),  32'(m_bo[k]));
        chk({tag, ".pos"},   ip,       32'(m_ip[k]) & mask);
        chk({tag, ".bn"},    bn,       32'(m_bn[k]) & mask);
        chk({tag, ".bcnt"},  bc,       32'(m_bc[k]));
        chk({tag, ".err"},   32'(err), 32'(m_err[k]));
    endtask

    task automatic check_all(input string tag);
        check_inst({tag, "/m8"}, 0, 5, b8.consume_ready, b8.byte_req, b8.byte_load,
                   b8.byte_out, 32'(b8.insert_pos), 32'(b8.bits_needed),
                   32'(b8.bytes_fetched), b8.shift_err);
        check_inst({tag, "/m16"}, 1, 6, b16.consume_ready, b16.byte_req, b16.byte_load,
                   b16.byte_out, 32'(b16.insert_pos), 32'(b16.bits_needed),
                   32'(b16.bytes_fetched), b16.shift_err);
    endtask

    // Advance one clock with the currently driven inputs; entered at edge+1.
    task automatic tick(input string tag);
        model_step(0, 8);
        model_step(1, 16);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic cycle(input string tag, input logic in, input logic cv,
                         input logic [4:0] cb, input logic bv, input logic [7:0] bi);
        d_init = in; d_cv = cv; d_cb = cb; d_bv = bv; d_bi = bi;
        tick(tag);
    endtask

    initial begin
        rst = 1'b1;
        d_init = 1'b0; d_cv = 1'b0; d_cb = 5'd0; d_bv = 1'b0; d_bi = 8'h00;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        cycle("idle", 1'b0, 1'b1, 5'd3, 1'b1, 8'h11);
        chk("idle.ready", 32'(b8.consume_ready), 32'd0);
        cycle("init", 1'b1, 1'b0, 5'd0, 1'b0, 8'h00);
        cycle("c3", 1'b0, 1'b1, 5'd3, 1'b0, 8'h00);
        chk("c3.bn", 32'(b8.bits_needed), 32'h1B);
        cycle("c4", 1'b0, 1'b1, 5'd4, 1'b0, 8'h00);
        chk("c4.bn", 32'(b8.bits_needed), 32'h1F);
        chk("c4.req", 32'(b8.byte_req), 32'd0);
        cycle("c0", 1'b0, 1'b1, 5'd0, 1'b0, 8'h00);
        chk("c0.bn", 32'(b8.bits_needed), 32'h1F);
        cycle("c1", 1'b0, 1'b1, 5'd1, 1'b0, 8'h00);
        chk("c1.bn", 32'(b8.bits_needed), 32'h00);
        chk("c1.req", 32'(b8.byte_req), 32'd1);
        chk("c1.ready", 32'(b8.consume_ready), 32'd0);
        cycle("byte", 1'b0, 1'b0, 5'd0, 1'b1, 8'hA5);
        chk("byte.load", 32'(b8.byte_load), 32'd1);
        chk("byte.out", 32'(b8.byte_out), 32'hA5);
        chk("byte.pos", 32'(b8.insert_pos), 32'd0);
        chk("byte.bn", 32'(b8.bits_needed), 32'h18);
        chk("byte.ready", 32'(b8.consume_ready), 32'd1);
        chk("byte.bcnt", 32'(b8.bytes_fetched), 32'd1);
        cycle("stray", 1'b0, 1'b0, 5'd0, 1'b1, 8'h77);
        chk("stray.load", 32'(b8.byte_load), 32'd0);
        chk("stray.out", 32'(b8.byte_out), 32'hA5);

        cycle("pre38", 1'b0, 1'b1, 5'd8, 1'b0, 8'h00);
        cycle("initfetch", 1'b1, 1'b0, 5'd0, 1'b1, 8'h5A);
        chk("initfetch.load", 32'(b8.byte_load), 32'd0);
        chk("initfetch.bn", 32'(b8.bits_needed), 32'h18);
        chk("initfetch.bcnt", 32'(b8.bytes_fetched), 32'd0);
        chk("initfetch.req", 32'(b8.byte_req), 32'd0);

        cycle("clamp", 1'b0, 1'b1, 5'd12, 1'b0, 8'h00);
        chk("clamp.bn8", 32'(b8.bits_needed), 32'h00);
        chk("clamp.err8", 32'(b8.shift_err), 32'd1);
        chk("clamp.bn16", 32'(b16.bits_needed), 32'h04);
        chk("clamp.err16", 32'(b16.shift_err), 32'd0);
        cycle("clampb", 1'b0, 1'b0, 5'd0, 1'b1, 8'h01);
        cycle("clamph", 1'b0, 1'b0, 5'd0, 1'b0, 8'h00);
        chk("clamph.err8", 32'(b8.shift_err), 32'd1);
        cycle("clri", 1'b1, 1'b0, 5'd0, 1'b0, 8'h00);
        chk("clri.err8", 32'(b8.shift_err), 32'd0);

        cycle("w7", 1'b0, 1'b1, 5'd7, 1'b0, 8'h00);
        cycle("w16", 1'b0, 1'b1, 5'd16, 1'b0, 8'h00);
        chk("w16.bn16", 32'(b16.bits_needed), 32'h0F);
        cycle("wb1", 1'b0, 1'b0, 5'd0, 1'b1, 8'h3C);
        chk("wb1.pos16", 32'(b16.insert_pos), 32'd15);
        chk("wb1.req16", 32'(b16.byte_req), 32'd1);
        cycle("wb2", 1'b0, 1'b0, 5'd0, 1'b1, 8'hC3);
        chk("wb2.pos16", 32'(b16.insert_pos), 32'd7);
        chk("wb2.bn16", 32'(b16.bits_needed), 32'h3F);
        chk("wb2.ready16", 32'(b16.consume_ready), 32'd1);

        cycle("ar0", 1'b1, 1'b0, 5'd0, 1'b0, 8'h00);
        cycle("ar1", 1'b0, 1'b1, 5'd8, 1'b0, 8'h00);
        d_cv = 1'b0; d_bv = 1'b1; d_bi = 8'hFF;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        chk("arst.req", 32'(b8.byte_req), 32'd0);
        chk("arst.bn", 32'(b8.bits_needed), 32'h18);
        #1;
        rst = 1'b0;
        tick("arst_edge");
        cycle("arst_c1", 1'b0, 1'b1, 5'd8, 1'b0, 8'h00);
        chk("arst_c1.ready", 32'(b8.consume_ready), 32'd0);
        chk("arst_c1.bn", 32'(b8.bits_needed), 32'h18);

        cycle("rnd_init", 1'b1, 1'b0, 5'd0, 1'b0, 8'h00);
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", ($urandom_range(0, 24) == 0), 1'($urandom),
                  5'($urandom_range(0, 20)), 1'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bits_needed_tracker.md
BITS_NEEDED_TRACKER -- requirements
Module: bits_needed_tracker

Interface
REQ-001 Parameter MAX_SHIFT, default 8; maximum bits consumed per accepted transaction (regular renorm or bypass group), legal range 1..16.
REQ-002 Parameter CNT_W, default 5; width of signed bits-needed counter; must hold -8..MAX_SHIFT-1.
REQ-003 Parameter SHIFT_W, default 5; width of consume_bits; must hold MAX_SHIFT.
REQ-004 Parameter BCNT_W, default 16; width of fetched-byte counter.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 init  in  1  slice/tile start pulse; loads counter to -8 and enters RUN.
REQ-008 consume_valid  in  1  consume request valid.
REQ-009 consume_bits  in  SHIFT_W  bits consumed (numBits for bypass, renorm shift for regular).
REQ-010 consume_ready  out  1  tracker accepts consume this cycle.
REQ-011 byte_req  out  1  byte fetch request; also acts as ready for byte_valid.
REQ-012 byte_valid  in  1  fetched byte present.
REQ-013 byte_in  in  8  fetched bitstream byte.
REQ-014 byte_load  out  1  one-cycle pulse: byte_out to be OR-ed into value register.
REQ-015 byte_out  out  8  registered copy of accepted byte.
REQ-016 insert_pos  out  CNT_W  left-shift for byte_out (counter value at fetch, >= 0).
REQ-017 bits_needed  out  CNT_W  signed counter register.
REQ-018 bytes_fetched  out  BCNT_W  count of accepted bytes since last init.
REQ-019 shift_err  out  1  sticky: consume_bits > MAX_SHIFT seen.

Function
REQ-020 States: IDLE, RUN, FETCH; after reset state SHALL be IDLE.
REQ-021 IDLE: consume_ready=0, byte_req=0; only init leaves IDLE (-> RUN).
REQ-022 RUN: consume_ready=1, byte_req=0.
REQ-023 Consume accepted when consume_valid & consume_ready; n = bits_needed + min(consume_bits, MAX_SHIFT), signed, no overflow by REQ-002.
REQ-024 Accepted consume SHALL register bits_needed <= n at that edge; n < 0 -> stay RUN; n >= 0 -> go FETCH.
REQ-025 consume_bits = 0 SHALL be accepted with no counter change.
REQ-026 consume_bits > MAX_SHIFT SHALL be clamped to MAX_SHIFT and set shift_err.
REQ-027 FETCH: consume_ready=0, byte_req=1; byte accepted when byte_req & byte_valid.
REQ-028 On byte accept: next cycle byte_load=1, byte_out=byte_in, insert_pos=old bits_needed; bits_needed <= bits_needed-8; bytes_fetched +1, wrapping modulo 2^BCNT_W.
REQ-029 After byte accept: bits_needed-8 >= 0 -> stay FETCH (second byte, MAX_SHIFT > 8); else -> RUN.
REQ-030 byte_valid outside FETCH SHALL be ignored.
REQ-031 init has priority over consume and byte accept in the same cycle: bits_needed <= -8, bytes_fetched <= 0, state RUN, no byte_load, pending fetch cancelled; shift_err cleared.
REQ-032 byte_load low in all cycles except REQ-028; byte_out/insert_pos hold last values otherwise.

Reset
REQ-033 rst asserted SHALL immediately, regardless of clk: state IDLE, bits_needed=-8, bytes_fetched=0, insert_pos=0, byte_out=0, byte_load=0, byte_req=0, consume_ready=0, shift_err=0.
REQ-034 rst mid-FETCH SHALL drop byte_req asynchronously; byte in flight discarded.

Verification
REQ-035 Defaults; init; consume 3 -> bits_needed -5; consume 4 -> -1; byte_req stays 0.
REQ-036 From -1 consume 1 -> bits_needed 0, next cycle byte_req=1, consume_ready=0; byte_valid with 0xA5 -> next cycle byte_load=1, byte_out=0xA5, insert_pos=0, bits_needed=-8, consume_ready=1, bytes_fetched=1.
REQ-037 MAX_SHIFT=16, CNT_W=6: from -1 consume 16 -> 15; two byte accepts give insert_pos 15 then 7, final bits_needed -1, state RUN.
REQ-038 In FETCH, init and byte_valid same cycle -> no byte_load, bits_needed=-8, bytes_fetched=0, byte_req=0.
REQ-039 MAX_SHIFT=8: consume 12 from -8 -> treated as 8, bits_needed 0, shift_err=1 until next init.
REQ-040 rst pulsed between clk edges during FETCH -> all outputs at REQ-033 values before next edge; consume ignored until init.
